f1_start_ctrl: RTL

//  Sequencer for the F1 start-light FSM. On a trigger it issues 8 paced step

---
 rtl/f1_start_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/f1_start_ctrl.sv
// Start sequencer for the F1 light FSM: paces 8 fill steps, holds for a
// pseudo-random number of ticks, issues the lights-out step, then times the driver.
module f1_start_ctrl #(
  parameter int TICK_DIV = 16,
  parameter int MIN_HOLD = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             react_btn,
  output logic             fsm_en,
  output logic [3:0]       lights_on,
  output logic             busy,
  output logic             react_valid,
  output logic [CNT_W-1:0] react_time,
  output logic             jump_start,
  output logic             timeout
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(MIN_HOLD + 128);

  typedef enum logic [2:0] {IDLE, ARM, HOLD, REACT, DONE} state_t;

  state_t          state;
  logic [TW-1:0]   tick;
  logic [6:0]      lfsr;
  logic            btn_q;
  logic [HW-1:0]   hold_ticks;
  logic [CNT_W-1:0] rcnt;
  logic            js_flag;

  logic btn_edge, tick_wrap;
  assign btn_edge  = react_btn & ~btn_q;
  assign tick_wrap = (tick == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tick        <= '0;
      lfsr        <= 7'h01;
      btn_q       <= 1'b0;
      hold_ticks  <= '0;
      rcnt        <= '0;
      js_flag     <= 1'b0;
      fsm_en      <= 1'b0;
      lights_on   <= 4'd0;
      busy        <= 1'b0;
      react_valid <= 1'b0;
      react_time  <= '0;
      jump_start  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      lfsr        <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      btn_q       <= react_btn;
      fsm_en      <= 1'b0;
      react_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            state     <= ARM;
            tick      <= '0;
            lights_on <= 4'd0;
            js_flag   <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ARM: begin
          if (btn_edge) js_flag <= 1'b1;
          if (tick_wrap) begin
            tick      <= '0;
            fsm_en    <= 1'b1;
            lights_on <= lights_on + 4'd1;
            if (lights_on == 4'd7) begin
              state      <= HOLD;
              hold_ticks <= HW'(MIN_HOLD) + HW'(lfsr);
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        HOLD: begin
          // An edge on the lights-out cycle itself is a jump start, not a reaction.
          if (btn_edge) js_flag <= 1'b1;
          if (tick_wrap) begin
            tick <= '0;
            if (hold_ticks == HW'(1)) begin
              fsm_en    <= 1'b1;
              lights_on <= 4'd0;
              rcnt      <= '0;
              state     <= REACT;
            end else begin
              hold_ticks <= hold_ticks - 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        REACT: begin
          if (btn_edge || rcnt == '1) begin
            state       <= DONE;
            react_valid <= 1'b1;
            react_time  <= rcnt;
            timeout     <= ~btn_edge;
            jump_start  <= js_flag;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
